key_switch_conditioner: RTL and testbench

Input-conditioning stage between the board's raw pushbuttons/slide switches and the Nios II SoC's PIO inputs (accumulate, reset-accumulate, switch word). It synchronizes every asynchronous board input into the system clock domain, debounces each channel, and turns key presses into single-cycle pulses plus sticky pending flags that software clears with an acknowledge. The SoC and any fabric logic consume only its outputs, never raw KEY/SW.

---
 rtl/key_switch_pkg.sv | 18 +
 rtl/key_switch_conditioner_if.sv | 33 +++
 rtl/debounce_cell.sv | 65 ++++++
 rtl/key_switch_conditioner.sv | 74 +++++++
 tb/tb_key_switch_conditioner.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/key_switch_pkg.sv
// Shared constants and helpers for the key/switch input conditioner.
//   DEBOUNCE_CYCLES_DEFAULT : stable cycles before a change is accepted (10 ms @ 50 MHz)
//   KEY_INACTIVE            : raw level of a released pushbutton (active-low keys)
//   SW_INACTIVE             : raw level of a switch in the down position
//   cnt_width()             : width of the per-channel debounce counter
package key_switch_pkg;

    localparam int   DEBOUNCE_CYCLES_DEFAULT = 500000;
    localparam logic KEY_INACTIVE            = 1'b1;
    localparam logic SW_INACTIVE             = 1'b0;

    // The counter only has to reach cycles-1, so $clog2(cycles) bits suffice;
    // clamp to 1 bit so the smallest legal setting (2) still gets a counter.
    function automatic int cnt_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/key_switch_conditioner_if.sv
// Bundle of the board-side inputs and conditioned outputs of the conditioner.
//   key_raw_n     : raw pushbuttons, 0 = pressed
//   sw_raw        : raw slide switches
//   press_ack     : per-key clear of press_pending
//   key_level     : debounced key state, 1 = held
//   key_press     : one-cycle pulse on accepted press
//   key_release   : one-cycle pulse on accepted release
//   press_pending : sticky press flag
//   sw_level      : debounced switch word
// Modports: slave = the conditioner, master = the consumer driving raw inputs/acks.
interface key_switch_conditioner_if #(
    parameter int NUM_KEYS = 4,
    parameter int NUM_SW   = 8
);
    logic [NUM_KEYS-1:0] key_raw_n;
    logic [NUM_SW-1:0]   sw_raw;
    logic [NUM_KEYS-1:0] press_ack;
    logic [NUM_KEYS-1:0] key_level;
    logic [NUM_KEYS-1:0] key_press;
    logic [NUM_KEYS-1:0] key_release;
    logic [NUM_KEYS-1:0] press_pending;
    logic [NUM_SW-1:0]   sw_level;

    modport slave (
        input  key_raw_n, sw_raw, press_ack,
        output key_level, key_press, key_release, press_pending, sw_level
    );

    modport master (
        output key_raw_n, sw_raw, press_ack,
        input  key_level, key_press, key_release, press_pending, sw_level
    );
endinterface

// File: rtl/debounce_cell.sv
// One input channel: 2-flop synchronizer, stability counter, accepted state q
// and registered one-cycle rise/fall pulses on each accepted change.
//   clk, rst : system clock, asynchronous active-high reset
//   raw      : asynchronous board input
//   q        : debounced (accepted) level, in raw polarity
//   rise     : pulse when q is accepted 0 -> 1
//   fall     : pulse when q is accepted 1 -> 0
module debounce_cell
    import key_switch_pkg::*;
#(
    parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter logic RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic q,
    output logic rise,
    output logic fall
);

    localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_reg;
    logic          sync2_reg;
    logic          q_reg;
    logic [CW-1:0] cnt_reg;
    logic          rise_reg;
    logic          fall_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // Sync flops start at the inactive level so a key held through
            // reset is seen as a fresh change afterwards.
            sync1_reg <= RESET_VAL;
            sync2_reg <= RESET_VAL;
            q_reg     <= RESET_VAL;
            cnt_reg   <= '0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
        end else begin
            sync1_reg <= raw;
            sync2_reg <= sync1_reg;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            if (sync2_reg == q_reg) begin
                // Any bounce back to the accepted level discards progress.
                cnt_reg <= '0;
            end else if (cnt_reg == CNT_MAX) begin
                q_reg    <= sync2_reg;
                cnt_reg  <= '0;
                rise_reg <= sync2_reg;
                fall_reg <= ~sync2_reg;
            end else begin
                cnt_reg <= cnt_reg + 1'b1;
            end
        end
    end

    assign q    = q_reg;
    assign rise = rise_reg;
    assign fall = fall_reg;

endmodule

// File: rtl/key_switch_conditioner.sv
// Conditions raw board pushbuttons and slide switches for the SoC PIO inputs:
// every channel is synchronized and debounced; keys additionally produce
// press/release pulses and a sticky press_pending flag cleared by press_ack.
//   clk : system clock (50 MHz)
//   rst : asynchronous active-high reset, clears all state
//   bus : key_switch_conditioner_if.slave (raw inputs, acks, conditioned outputs)
module key_switch_conditioner
    import key_switch_pkg::*;
#(
    parameter int NUM_KEYS        = 4,
    parameter int NUM_SW          = 8,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
    input  logic                     clk,
    input  logic                     rst,
    key_switch_conditioner_if.slave  bus
);

    logic [NUM_KEYS-1:0] key_q;
    logic [NUM_KEYS-1:0] key_rise;
    logic [NUM_KEYS-1:0] key_fall;
    logic [NUM_KEYS-1:0] pending_reg;
    logic [NUM_SW-1:0]   sw_q;
    logic [NUM_SW-1:0]   sw_rise_unused;
    logic [NUM_SW-1:0]   sw_fall_unused;

    generate
        for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_key
            debounce_cell #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (KEY_INACTIVE)
            ) u_cell (
                .clk  (clk),
                .rst  (rst),
                .raw  (bus.key_raw_n[gi]),
                .q    (key_q[gi]),
                .rise (key_rise[gi]),
                .fall (key_fall[gi])
            );
        end

        for (genvar gi = 0; gi < NUM_SW; gi++) begin : g_sw
            debounce_cell #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
                .RESET_VAL       (SW_INACTIVE)
            ) u_cell (
                .clk  (clk),
                .rst  (rst),
                .raw  (bus.sw_raw[gi]),
                .q    (sw_q[gi]),
                .rise (sw_rise_unused[gi]),
                .fall (sw_fall_unused[gi])
            );
        end
    endgenerate

    // Keys are active-low, so an accepted press is a fall of q. The pending
    // flag is set from the visible key_press pulse, which lets a press win
    // over an ack sampled in that same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending_reg <= '0;
        end else begin
            pending_reg <= key_fall | (pending_reg & ~bus.press_ack);
        end
    end

    assign bus.key_level     = ~key_q;
    assign bus.key_press     = key_fall;
    assign bus.key_release   = key_rise;
    assign bus.press_pending = pending_reg;
    assign bus.sw_level      = sw_q;

endmodule

// File: tb/tb_key_switch_conditioner.sv
module tb_key_switch_conditioner;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    key_switch_conditioner_if #(.NUM_KEYS(4), .NUM_SW(8)) bus ();

    key_switch_conditioner #(
        .NUM_KEYS        (4),
        .NUM_SW          (8),
        .DEBOUNCE_CYCLES (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic [3:0] key_n;
        logic [7:0] sw;
        logic [3:0] ack;
        int         steps;
        logic [3:0] e_level;
        logic [3:0] e_press;
        logic [3:0] e_release;
        logic [3:0] e_pending;
        logic [7:0] e_sw;
    } vec_t;

    vec_t vecs[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    function automatic vec_t mk(string name, logic [3:0] key_n, logic [7:0] sw,
                                logic [3:0] ack, int steps, logic [3:0] lvl,
                                logic [3:0] prs, logic [3:0] rel,
                                logic [3:0] pnd, logic [7:0] swl);
        vec_t v;
        v.name = name; v.key_n = key_n; v.sw = sw; v.ack = ack; v.steps = steps;
        v.e_level = lvl; v.e_press = prs; v.e_release = rel;
        v.e_pending = pnd; v.e_sw = swl;
        return v;
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string name, input vec_t v);
        check({name, ".key_level"},     {4'h0, bus.key_level},     {4'h0, v.e_level});
        check({name, ".key_press"},     {4'h0, bus.key_press},     {4'h0, v.e_press});
        check({name, ".key_release"},   {4'h0, bus.key_release},   {4'h0, v.e_release});
        check({name, ".press_pending"}, {4'h0, bus.press_pending}, {4'h0, v.e_pending});
        check({name, ".sw_level"},      bus.sw_level,              v.e_sw);
    endtask

    // Advance one clock; inputs and samples both sit 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec_t zero_v;
        int   n_press;
        int   first_press;

        //                name           key_n  sw     ack   steps lvl   prs   rel   pnd   sw
        vecs.push_back(mk("reset_idle",   4'hF, 8'h00, 4'h0, 2,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        // Clean press/release of key 3.
        vecs.push_back(mk("k3_wait",      4'h7, 8'h00, 4'h0, 5,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("k3_press",     4'h7, 8'h00, 4'h0, 1,    4'h8, 4'h8, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("k3_after",     4'h7, 8'h00, 4'h0, 1,    4'h8, 4'h0, 4'h0, 4'h8, 8'h00));
        vecs.push_back(mk("k3_rel",       4'hF, 8'h00, 4'h0, 6,    4'h0, 4'h0, 4'h8, 4'h8, 8'h00));
        vecs.push_back(mk("k3_rel_after", 4'hF, 8'h00, 4'h0, 1,    4'h0, 4'h0, 4'h0, 4'h8, 8'h00));
        vecs.push_back(mk("k3_ack",       4'hF, 8'h00, 4'h8, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("ack_noop",     4'hF, 8'h00, 4'h8, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("ack_off",      4'hF, 8'h00, 4'h0, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        // Key 0 bounces 0,1,0,1 then settles low.
        vecs.push_back(mk("b0",           4'hE, 8'h00, 4'h0, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("b1",           4'hF, 8'h00, 4'h0, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("b2",           4'hE, 8'h00, 4'h0, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("b3",           4'hF, 8'h00, 4'h0, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("b_hold",       4'hE, 8'h00, 4'h0, 5,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("b_press",      4'hE, 8'h00, 4'h0, 1,    4'h1, 4'h1, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("b_after",      4'hE, 8'h00, 4'h0, 1,    4'h1, 4'h0, 4'h0, 4'h1, 8'h00));
        vecs.push_back(mk("b_ack",        4'hE, 8'h00, 4'h1, 1,    4'h1, 4'h0, 4'h0, 4'h0, 8'h00));
        // Key 1 press with ack in the same cycle as key_press.
        vecs.push_back(mk("k1_wait",      4'hC, 8'h00, 4'h0, 5,    4'h1, 4'h0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("k1_press",     4'hC, 8'h00, 4'h0, 1,    4'h3, 4'h2, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("k1_ack_same",  4'hC, 8'h00, 4'h2, 1,    4'h3, 4'h0, 4'h0, 4'h2, 8'h00));
        vecs.push_back(mk("k1_hold",      4'hC, 8'h00, 4'h0, 1,    4'h3, 4'h0, 4'h0, 4'h2, 8'h00));
        vecs.push_back(mk("k1_ack",       4'hC, 8'h00, 4'h2, 1,    4'h3, 4'h0, 4'h0, 4'h0, 8'h00));
        // Simultaneous release of keys 0 and 1.
        vecs.push_back(mk("rel_both",     4'hF, 8'h00, 4'h0, 6,    4'h0, 4'h0, 4'h3, 4'h0, 8'h00));
        vecs.push_back(mk("rel_after",    4'hF, 8'h00, 4'h0, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        // Switch word 00 -> A5 with a one-cycle glitch on bit 0.
        vecs.push_back(mk("sw_a",         4'hF, 8'hA5, 4'h0, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("sw_glitch",    4'hF, 8'hA4, 4'h0, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'h00));
        vecs.push_back(mk("sw_main",      4'hF, 8'hA5, 4'h0, 4,    4'h0, 4'h0, 4'h0, 4'h0, 8'hA4));
        vecs.push_back(mk("sw_b0_wait",   4'hF, 8'hA5, 4'h0, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'hA4));
        vecs.push_back(mk("sw_b0",        4'hF, 8'hA5, 4'h0, 1,    4'h0, 4'h0, 4'h0, 4'h0, 8'hA5));
        vecs.push_back(mk("sw_hold",      4'hF, 8'hA5, 4'h0, 3,    4'h0, 4'h0, 4'h0, 4'h0, 8'hA5));

        bus.key_raw_n = 4'hF;
        bus.sw_raw    = 8'h00;
        bus.press_ack = 4'h0;
        rst = 1'b1;
        repeat (3) step();
        rst = 1'b0;

        foreach (vecs[i]) begin
            bus.key_raw_n = vecs[i].key_n;
            bus.sw_raw    = vecs[i].sw;
            bus.press_ack = vecs[i].ack;
            repeat (vecs[i].steps) step();
            check_all(vecs[i].name, vecs[i]);
            $display("vec %0d %s: key_n=%h sw=%h ack=%h -> level=%h press=%h rel=%h pend=%h sw_level=%h",
                     i, vecs[i].name, vecs[i].key_n, vecs[i].sw, vecs[i].ack,
                     bus.key_level, bus.key_press, bus.key_release,
                     bus.press_pending, bus.sw_level);
        end

        // Reset mid-run with key 2 held and its pending flag set.
        bus.sw_raw    = 8'h00;
        bus.press_ack = 4'h0;
        bus.key_raw_n = 4'hB;
        repeat (7) step();
        check("rst_pre.key_level",     {4'h0, bus.key_level},     8'h04);
        check("rst_pre.press_pending", {4'h0, bus.press_pending}, 8'h04);
        #2;
        rst = 1'b1;
        #1;
        zero_v = mk("zero", 4'hF, 8'h00, 4'h0, 0, 4'h0, 4'h0, 4'h0, 4'h0, 8'h00);
        // sw_level was A5 before this sequence; it must also be cleared.
        check_all("rst_async", zero_v);
        step();
        check_all("rst_held", zero_v);
        rst = 1'b0;
        n_press     = 0;
        first_press = 0;
        for (int k = 1; k <= 12; k++) begin
            step();
            if (bus.key_press[2]) begin
                n_press++;
                if (first_press == 0) first_press = k;
            end
            if (k == 1) check("rst_release.key_press", {4'h0, bus.key_press}, 8'h00);
        end
        check("rst_repress.count", n_press[7:0],     8'd1);
        check("rst_repress.cycle", first_press[7:0], 8'd6);
        check("rst_repress.level", {4'h0, bus.key_level}, 8'h04);
        $display("reset sequence: presses=%0d first_at=%0d level=%h pend=%h",
                 n_press, first_press, bus.key_level, bus.press_pending);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
